// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, ALU ops, immediate
// formats, FSM state encodings and decode helpers.
package core_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  localparam logic [31:0] InstrEcall  = 32'h0000_0073;
  localparam logic [31:0] InstrEbreak = 32'h0010_0073;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_type_e;

  localparam logic [2:0] StFetch     = 3'd0;
  localparam logic [2:0] StDecode    = 3'd1;
  localparam logic [2:0] StExecute   = 3'd2;
  localparam logic [2:0] StWriteback = 3'd3;
  localparam logic [2:0] StStepWait  = 3'd4;
  localparam logic [2:0] StHalt      = 3'd5;

  // alt selects SUB/SRA, i.e. funct7[5] where that bit is meaningful.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    op = AluAdd;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] ir, input imm_type_e t);
    logic [31:0] imm;
    case (t)
      ImmS:    imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      ImmB:    imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      ImmU:    imm = {ir[31:12], 12'b0};
      ImmJ:    imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = {{20{ir[31]}}, ir[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational RV32I ALU with branch comparison flags.
module core_alu
  import core_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = a + b;
    unique case (op)
      AluAdd:  result = a + b;
      AluSub:  result = a - b;
      AluSll:  result = a << shamt;
      AluSlt:  result = {31'b0, $signed(a) < $signed(b)};
      AluSltu: result = {31'b0, a < b};
      AluXor:  result = a ^ b;
      AluSrl:  result = a >> shamt;
      AluSra:  result = $unsigned($signed(a) >>> shamt);
      AluOr:   result = a | b;
      AluAnd:  result = a & b;
      default: result = a + b;
    endcase
  end

  assign eq  = a == b;
  assign lt  = $signed(a) < $signed(b);
  assign ltu = a < b;

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I/RV32E integer core: fetch over req/ack, decode, execute,
// writeback, with single-step, halt and illegal-instruction detection.
module multicycle_core
  import core_pkg::*;
#(
  parameter int unsigned NREGS    = 32,
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter bit          STEP_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_mode,
  input  logic        step,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        retire,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] dbg_pc,
  output logic [31:0] dbg_alu,
  output logic [31:0] dbg_rs1,
  output logic [31:0] dbg_rs2
);

  localparam int unsigned RegAw = $clog2(NREGS);

  logic [2:0]  state_q;
  logic [31:0] pc_q, ir_q, rs1_q, rs2_q, imm_q;
  logic [31:0] alu_q, opa_q, opb_q, target_q;
  logic        taken_q, illegal_q, step_q, ack_block_q;
  logic [31:0] regs_q [NREGS];

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  logic cls_op, cls_opimm, cls_lui, cls_auipc, cls_branch, cls_jal, cls_jalr;
  logic is_trap, dec_illegal, uses_rs1, uses_rs2, uses_rd;
  imm_type_e imm_type;
  alu_op_e   alu_op;

  always_comb begin
    cls_op = 1'b0; cls_opimm = 1'b0; cls_lui = 1'b0; cls_auipc = 1'b0;
    cls_branch = 1'b0; cls_jal = 1'b0; cls_jalr = 1'b0;
    is_trap = 1'b0; dec_illegal = 1'b0;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0; uses_rd = 1'b0;
    imm_type = ImmI;
    alu_op = AluAdd;
    case (opcode)
      OpcOp: begin
        cls_op = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; uses_rd = 1'b1;
        if (funct7 == 7'b0000000) alu_op = alu_from_f3(funct3, 1'b0);
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          alu_op = alu_from_f3(funct3, 1'b1);
        else dec_illegal = 1'b1;
      end
      OpcOpImm: begin
        cls_opimm = 1'b1; uses_rs1 = 1'b1; uses_rd = 1'b1;
        if (funct3 == 3'b001) begin
          alu_op = AluSll;
          dec_illegal = funct7 != 7'b0000000;
        end else if (funct3 == 3'b101) begin
          alu_op = funct7[5] ? AluSra : AluSrl;
          dec_illegal = funct7 != 7'b0000000 && funct7 != 7'b0100000;
        end else begin
          alu_op = alu_from_f3(funct3, 1'b0);
        end
      end
      OpcLui:   begin cls_lui = 1'b1;   uses_rd = 1'b1; imm_type = ImmU; end
      OpcAuipc: begin cls_auipc = 1'b1; uses_rd = 1'b1; imm_type = ImmU; end
      OpcBranch: begin
        cls_branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_type = ImmB;
        dec_illegal = funct3[2:1] == 2'b01;
      end
      OpcJal: begin cls_jal = 1'b1; uses_rd = 1'b1; imm_type = ImmJ; end
      OpcJalr: begin
        cls_jalr = 1'b1; uses_rs1 = 1'b1; uses_rd = 1'b1;
        dec_illegal = funct3 != 3'b000;
      end
      OpcSystem: begin
        if (ir_q == InstrEcall || ir_q == InstrEbreak) is_trap = 1'b1;
        else dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Any referenced register index with bits at or above RegAw does not exist.
    if ((uses_rd && |(rd >> RegAw)) || (uses_rs1 && |(rs1 >> RegAw)) ||
        (uses_rs2 && |(rs2 >> RegAw)))
      dec_illegal = 1'b1;
  end

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : regs_q[idx[RegAw-1:0]];
  endfunction

  logic [31:0] alu_b, alu_res;
  logic        alu_eq, alu_lt, alu_ltu;
  assign alu_b = (cls_op || cls_branch) ? rs2_q : imm_q;

  core_alu u_alu (
    .a      (rs1_q),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .eq     (alu_eq),
    .lt     (alu_lt),
    .ltu    (alu_ltu)
  );

  logic br_cond;
  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:  br_cond = alu_eq;
      3'b001:  br_cond = !alu_eq;
      3'b100:  br_cond = alu_lt;
      3'b101:  br_cond = !alu_lt;
      3'b110:  br_cond = alu_ltu;
      3'b111:  br_cond = !alu_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  logic        ex_taken;
  logic [31:0] ex_target, next_pc, wb_data;
  logic        misalign, step_go, step_rise;
  assign ex_taken  = cls_branch ? br_cond : (cls_jal || cls_jalr);
  assign ex_target = cls_jalr ? {alu_res[31:1], 1'b0} : pc_q + imm_q;
  assign next_pc   = taken_q ? target_q : pc_q + 32'd4;
  assign misalign  = next_pc[1];
  assign step_go   = STEP_EN && step_mode;
  assign step_rise = step && !step_q;

  always_comb begin
    wb_data = alu_q;
    if (cls_lui) wb_data = imm_q;
    else if (cls_auipc) wb_data = pc_q + imm_q;
    else if (cls_jal || cls_jalr) wb_data = pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      target_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      regs_q    <= '{default: '0};
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_req && imem_ack) begin
            ir_q    <= imem_rdata;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          rs1_q <= rf_read(rs1);
          rs2_q <= rf_read(rs2);
          imm_q <= gen_imm(ir_q, imm_type);
          if (dec_illegal) begin
            illegal_q <= 1'b1;
            state_q   <= StHalt;
          end else if (is_trap) begin
            state_q <= StHalt;
          end else begin
            state_q <= StExecute;
          end
        end
        StExecute: begin
          alu_q    <= alu_res;
          opa_q    <= rs1_q;
          opb_q    <= alu_b;
          taken_q  <= ex_taken;
          target_q <= ex_target;
          state_q  <= StWriteback;
        end
        StWriteback: begin
          if (misalign) begin
            illegal_q <= 1'b1;
            state_q   <= StHalt;
          end else begin
            if (uses_rd && rd != 5'd0) regs_q[rd[RegAw-1:0]] <= wb_data;
            pc_q    <= next_pc;
            state_q <= step_go ? StStepWait : StFetch;
          end
        end
        StStepWait: begin
          if (!step_go || step_rise) state_q <= StFetch;
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StHalt;
      endcase
    end
  end

  // ack_block_q masks the request for one cycle after reset so a stale ack is dropped.
  always_ff @(posedge clk) begin
    ack_block_q <= rst;
    step_q      <= rst ? 1'b0 : step;
  end

  assign imem_req  = (state_q == StFetch) && !ack_block_q && !rst;
  assign imem_addr = pc_q;
  assign retire    = (state_q == StWriteback) && !misalign;
  assign halted    = state_q == StHalt;
  assign illegal   = illegal_q;
  assign dbg_pc    = pc_q;
  assign dbg_alu   = alu_q;
  assign dbg_rs1   = opa_q;
  assign dbg_rs2   = opb_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: directed programs, expected retires queued
// up front and checked by an independent retire monitor.
module tb_multicycle_core;

  localparam logic [31:0] Ebreak = 32'h0010_0073;
  localparam logic [31:0] Stale  = 32'h0630_0493;  // addi x9,x0,99

  logic        clk, rst, step_mode, step;
  logic        imem_req, imem_ack, retire, halted, illegal;
  logic [31:0] imem_addr, imem_rdata, dbg_pc, dbg_alu, dbg_rs1, dbg_rs2;

  logic        req16, ack16, retire16, halted16, illegal16;
  logic [31:0] addr16, rdata16, dbg16_pc, dbg16_alu, dbg16_rs1, dbg16_rs2;

  multicycle_core u_dut (
    .clk(clk), .rst(rst), .step_mode(step_mode), .step(step),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .retire(retire), .halted(halted), .illegal(illegal),
    .dbg_pc(dbg_pc), .dbg_alu(dbg_alu), .dbg_rs1(dbg_rs1), .dbg_rs2(dbg_rs2)
  );

  multicycle_core #(.NREGS(16)) u_dut16 (
    .clk(clk), .rst(rst), .step_mode(step_mode), .step(step),
    .imem_req(req16), .imem_addr(addr16), .imem_ack(ack16),
    .imem_rdata(rdata16), .retire(retire16), .halted(halted16), .illegal(illegal16),
    .dbg_pc(dbg16_pc), .dbg_alu(dbg16_alu), .dbg_rs1(dbg16_rs1), .dbg_rs2(dbg16_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    bit          chk_alu;
    int          gap;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, last_cyc = 0, retire_cnt = 0, r16_cnt = 0;
  int          delay = 0, wait_cnt = 0;
  bit          stale = 1'b0;
  logic [31:0] req_addr;
  logic [31:0] mem [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] alu, input bit c, input int gap);
    exp_t e;
    e.pc = pc; e.alu = alu; e.chk_alu = c; e.gap = gap;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = Ebreak;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory with configurable ack delay, plus an always-ready one for u_dut16.
  always @(negedge clk) begin
    ack16   = req16;
    rdata16 = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd20);
    if (stale) begin
      imem_ack   = 1'b1;
      imem_rdata = Stale;
      wait_cnt   = 0;
    end else if (imem_req) begin
      if (wait_cnt == 0) req_addr = imem_addr;
      else chk("addr_stable", imem_addr, req_addr);
      if (wait_cnt == delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr[7:2]];
        wait_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // Retire monitor: pops one expectation per retire pulse.
  always @(negedge clk) begin
    exp_t e;
    if (retire16) r16_cnt++;
    if (retire) begin
      retire_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_retire_pc", dbg_pc, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        chk("retire_pc", dbg_pc, e.pc);
        if (e.chk_alu) chk("retire_alu", dbg_alu, e.alu);
        if (e.gap != 0) chk("retire_gap", 32'(cyc - last_cyc), 32'(e.gap));
      end
      last_cyc = cyc;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", dbg_pc, 32'd0);
    chk("rst_dbg", dbg_alu | dbg_rs1 | dbg_rs2, 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string name, input logic exp_ill, input logic [31:0] exp_pc);
    int n;
    n = 0;
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_halted"}, {31'b0, halted}, 32'd1);
    chk({name, "_illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
    chk({name, "_pc"}, dbg_pc, exp_pc);
    chk({name, "_pending"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic load_arith();
    clear_mem();
    mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);
    mem[1] = enc_i(12'hffd, 5'd0, 3'b000, 5'd2, 7'h13);
    mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    mem[3] = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
  endtask

  task automatic run_arith(input string name, input int dly, input int gap);
    delay = dly;
    load_arith();
    push(32'h0, 32'd5, 1'b1, 0);
    push(32'h4, 32'hffff_fffd, 1'b1, gap);
    push(32'h8, 32'd2, 1'b1, gap);
    push(32'hc, 32'd8, 1'b1, gap);
    do_reset();
    wait_halt(name, 1'b0, 32'h10);
  endtask

  initial begin
    int mark;
    rst = 1'b1; step_mode = 1'b0; step = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; ack16 = 1'b0; rdata16 = '0;
    clear_mem();

    run_arith("arith_fast", 0, 4);
    chk("x20_halted", {31'b0, halted16}, 32'd1);
    chk("x20_illegal", {31'b0, illegal16}, 32'd1);
    chk("x20_pc", dbg16_pc, 32'd0);
    chk("x20_no_retire", 32'(r16_cnt), 32'd0);
    chk("x20_dbg", dbg16_alu | dbg16_rs1 | dbg16_rs2 | addr16, 32'd0);

    run_arith("arith_slow", 3, 7);

    // Branches and JAL; x5 observed through a following ADDI.
    delay = 0;
    clear_mem();
    mem[0] = enc_b(13'd8, 5'd1, 5'd1, 3'b000);
    mem[2] = enc_b(13'd8, 5'd1, 5'd1, 3'b001);
    mem[3] = enc_j(21'd16, 5'd5);
    mem[7] = enc_i(12'd0, 5'd5, 3'b000, 5'd7, 7'h13);
    push(32'h0, 32'd0, 1'b0, 0);
    push(32'h8, 32'd0, 1'b0, 4);
    push(32'hc, 32'd0, 1'b0, 4);
    push(32'h1c, 32'h10, 1'b1, 4);
    do_reset();
    wait_halt("branch", 1'b0, 32'h20);

    // Shifts, SLTU, x0 write discard, then an illegal word.
    clear_mem();
    mem[0] = {20'h80000, 5'd10, 7'h37};
    mem[1] = enc_i(12'h404, 5'd10, 3'b101, 5'd11, 7'h13);
    mem[2] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);
    mem[3] = enc_r(7'h00, 5'd1, 5'd0, 3'b011, 5'd6);
    mem[4] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'h13);
    mem[5] = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd8);
    mem[6] = 32'hffff_ffff;
    push(32'h0, 32'd0, 1'b0, 0);
    push(32'h4, 32'hf800_0000, 1'b1, 4);
    push(32'h8, 32'd5, 1'b1, 4);
    push(32'hc, 32'd1, 1'b1, 4);
    push(32'h10, 32'd7, 1'b1, 4);
    push(32'h14, 32'd0, 1'b1, 4);
    do_reset();
    wait_halt("illegal_word", 1'b1, 32'h18);

    // JAL to a target with bit1 set halts without retiring.
    clear_mem();
    mem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'h13);
    mem[1] = enc_j(21'd6, 5'd1);
    push(32'h0, 32'd1, 1'b1, 0);
    do_reset();
    wait_halt("misalign", 1'b1, 32'h4);

    // Single-step: held step releases exactly one instruction.
    clear_mem();
    mem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'h13);
    mem[1] = enc_i(12'd2, 5'd0, 3'b000, 5'd2, 7'h13);
    mem[2] = enc_i(12'd3, 5'd0, 3'b000, 5'd3, 7'h13);
    step_mode = 1'b1;
    push(32'h0, 32'd1, 1'b1, 0);
    mark = retire_cnt;
    do_reset();
    repeat (20) @(negedge clk);
    chk("step_first", 32'(retire_cnt - mark), 32'd1);
    mark = retire_cnt;
    push(32'h4, 32'd2, 1'b1, 0);
    @(posedge clk); #2 step = 1'b1;
    repeat (10) @(posedge clk);
    #2 step = 1'b0;
    repeat (10) @(negedge clk);
    chk("step_one", 32'(retire_cnt - mark), 32'd1);
    push(32'h8, 32'd3, 1'b1, 0);
    @(posedge clk); #2 step_mode = 1'b0;
    wait_halt("step", 1'b0, 32'hc);

    // Reset mid-fetch with a stale ack during and just after reset.
    delay = 5;
    clear_mem();
    mem[0] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    push(32'h0, 32'd0, 1'b1, 0);
    do_reset();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1; stale = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    chk("stale_req_blocked", {31'b0, imem_req}, 32'd0);
    chk("stale_pc", dbg_pc, 32'd0);
    @(posedge clk);
    #2 stale = 1'b0;
    wait_halt("stale", 1'b0, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
